// File: rtl/rsa_job_scheduler_pkg.sv
// Shared types and helpers for the rsa4k job scheduler.
package rsa_job_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RUN    = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned idw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsa_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
module rr_arbiter
    import rsa_job_scheduler_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one rsa4k core between NREQ requesters: round-robin accept, go/done
// sequencing, optional watchdog abort and a fixed re-arm gap between jobs.
module rsa_job_scheduler
    import rsa_job_scheduler_pkg::*;
#(
    parameter  int unsigned WIDTH      = 4096,
    parameter  int unsigned NREQ       = 2,
    parameter  int unsigned GAP_CYCLES = 2,
    parameter  int unsigned TIMEOUT    = 0,
    localparam int unsigned IDW        = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_message,
    input  logic [NREQ*WIDTH-1:0] req_exponent,
    input  logic [NREQ*WIDTH-1:0] req_modulus,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_cypher,
    output logic                  rsp_error,
    output logic                  core_go,
    output logic [WIDTH-1:0]      core_message,
    output logic [WIDTH-1:0]      core_exponent,
    output logic [WIDTH-1:0]      core_modulus,
    input  logic [WIDTH-1:0]      core_cypher,
    input  logic                  core_done,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    localparam int unsigned WD_W  = idw(TIMEOUT);
    localparam int unsigned GAP_W = idw(GAP_CYCLES);

    state_t          state, next_state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  sel;
    logic [WD_W-1:0] wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic            wd_expire;
    logic            gap_last;
    logic [IDW-1:0]  rr_next;

    logic [WIDTH-1:0] msg_slice [NREQ];
    logic [WIDTH-1:0] exp_slice [NREQ];
    logic [WIDTH-1:0] mod_slice [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign msg_slice[g] = req_message[g*WIDTH +: WIDTH];
        assign exp_slice[g] = req_exponent[g*WIDTH +: WIDTH];
        assign mod_slice[g] = req_modulus[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign rr_next   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (arb_any) next_state = ACCEPT;
            ACCEPT:  next_state = RUN;
            RUN:     if (core_done || wd_expire) next_state = GAP;
            GAP:     if (gap_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is combinational in IDLE, so it is masked while reset is held.
    always_comb begin
        req_ready = (state == IDLE && reset) ? arb_grant : '0;
        core_go   = (state == RUN);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            sel           <= '0;
            grant_id      <= '0;
            wd_cnt        <= '0;
            gap_cnt       <= '0;
            core_message  <= '0;
            core_exponent <= '0;
            core_modulus  <= '0;
            rsp_valid     <= '0;
            rsp_cypher    <= '0;
            rsp_error     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_any) sel <= arb_idx;
                end
                ACCEPT: begin
                    core_message  <= msg_slice[sel];
                    core_exponent <= exp_slice[sel];
                    core_modulus  <= mod_slice[sel];
                    grant_id      <= sel;
                    wd_cnt        <= '0;
                    gap_cnt       <= '0;
                end
                RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // done takes priority over a watchdog expiring in the same cycle
                    if (core_done) begin
                        rsp_valid  <= NREQ'(1) << grant_id;
                        rsp_cypher <= core_cypher;
                        rsp_error  <= 1'b0;
                        rr_ptr     <= rr_next;
                    end else if (wd_expire) begin
                        rsp_valid  <= NREQ'(1) << grant_id;
                        rsp_cypher <= '0;
                        rsp_error  <= 1'b1;
                        rr_ptr     <= rr_next;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Self-checking bench: behavioural stub core, job-level scheduler model, directed scenarios.
module tb_rsa_job_scheduler;

    localparam int W   = 16;
    localparam int GAP = 2;
    localparam int TMO = 64;
    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_STUCK  = 2;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_message, req_exponent, req_modulus;
    logic [1:0]    rsp_valid;
    logic [W-1:0]  rsp_cypher;
    logic          rsp_error;
    logic          core_go;
    logic [W-1:0]  core_message, core_exponent, core_modulus;
    logic [W-1:0]  core_cypher;
    logic          core_done;
    logic          busy;
    logic [0:0]    grant_id;

    logic [W-1:0] op_msg [2];
    logic [W-1:0] op_exp [2];
    logic [W-1:0] op_mod [2];
    int           left [2];

    assign req_message  = {op_msg[1], op_msg[0]};
    assign req_exponent = {op_exp[1], op_exp[0]};
    assign req_modulus  = {op_mod[1], op_mod[0]};

    rsa_job_scheduler #(
        .WIDTH(W), .NREQ(2), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_message(req_message), .req_exponent(req_exponent), .req_modulus(req_modulus),
        .rsp_valid(rsp_valid), .rsp_cypher(rsp_cypher), .rsp_error(rsp_error),
        .core_go(core_go), .core_message(core_message), .core_exponent(core_exponent),
        .core_modulus(core_modulus), .core_cypher(core_cypher), .core_done(core_done),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint r, x;
        if (m == 0) return '0;
        r = 1 % longint'(m);
        x = longint'(b) % longint'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % longint'(m);
            x = (x * x) % longint'(m);
        end
        return W'(r);
    endfunction

    // Stub rsa4k: done after `lat` go-high cycles, never, or stuck high.
    int mode = M_NORMAL;
    int lat  = 5;
    int go_cnt;
    initial begin
        core_done   = 1'b0;
        core_cypher = '0;
        go_cnt      = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset || !core_go) go_cnt = 0;
            else                    go_cnt++;
            core_done   = (mode == M_STUCK) || (mode == M_NORMAL && core_go && go_cnt >= lat);
            core_cypher = core_go ? modexp(core_message, core_exponent, core_modulus) : 16'hDEAD;
        end
    end

    // Requesters: hold valid while jobs remain, consume one per handshake.
    logic [1:0] seen;
    initial begin
        req_valid = '0;
        left[0] = 0; left[1] = 0;
        forever begin
            @(negedge clk);
            seen = req_ready & req_valid;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (seen[i] && left[i] > 0) left[i]--;
                req_valid[i] = (left[i] > 0);
            end
        end
    end

    // Observation logs (DUT-side) for the directed literal checks.
    int hs_port[$], hs_cyc[$];
    int rsp_port[$], rsp_cyc[$];
    logic [W-1:0] rsp_cyph[$];
    logic rsp_err[$];
    int rise_cyc[$], fall_cyc[$];

    // Job-level model state.
    int          cyc = 0;
    logic        prev_go = 1'b0;
    bit          m_open, m_pend;
    int          m_rr, m_free, m_rcyc, m_gocnt, m_port, m_win;
    logic [W-1:0] m_msg, m_exp, m_mod, m_cyph, m_pcyph;
    logic        m_err, m_perr;
    logic [1:0]  exp_ready, exp_rsp;
    logic        exp_go, exp_busy;

    initial begin
        m_open = 0; m_pend = 0; m_rr = 0; m_free = 0; m_rcyc = 0; m_gocnt = 0;
        m_port = 0; m_win = 0; m_cyph = '0; m_pcyph = '0; m_err = 0; m_perr = 0;
        m_msg = '0; m_exp = '0; m_mod = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (|req_ready) begin hs_port.push_back(req_ready[1] ? 1 : 0); hs_cyc.push_back(cyc); end
            if (|rsp_valid) begin
                rsp_port.push_back(rsp_valid[1] ? 1 : 0); rsp_cyc.push_back(cyc);
                rsp_cyph.push_back(rsp_cypher); rsp_err.push_back(rsp_error);
            end
            if (core_go && !prev_go) rise_cyc.push_back(cyc);
            if (!core_go && prev_go) fall_cyc.push_back(cyc);
            prev_go = core_go;

            if (!reset) begin
                chk("rst_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_go", 32'(core_go), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_grant", 32'(grant_id), 0);
                chk("rst_cypher", 32'(rsp_cypher), 0);
                chk("rst_core_msg", 32'(core_message), 0);
                m_open = 0; m_pend = 0; m_rr = 0; m_free = cyc; m_cyph = '0;
            end else begin
                exp_rsp = '0;
                if (m_pend) begin
                    exp_rsp[m_port] = 1'b1;
                    m_cyph = m_pcyph; m_err = m_perr;
                    m_open = 0; m_pend = 0;
                    m_rr = (m_port + 1) % 2;
                    m_free = cyc + GAP;
                end
                exp_go   = m_open && (cyc >= m_rcyc + 2);
                exp_busy = (m_open && cyc > m_rcyc) || (cyc < m_free);
                exp_ready = '0;
                if (!m_open && cyc >= m_free) begin
                    for (int k = 1; k >= 0; k--) begin
                        if (req_valid[(m_rr + k) % 2]) m_win = (m_rr + k) % 2;
                    end
                    if (|req_valid) exp_ready[m_win] = 1'b1;
                end
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
                chk("rsp_cypher", 32'(rsp_cypher), 32'(m_cyph));
                if (|exp_rsp) chk("rsp_error", 32'(rsp_error), 32'(m_err));
                chk("core_go", 32'(core_go), 32'(exp_go));
                chk("busy", 32'(busy), 32'(exp_busy));
                if (exp_go) begin
                    chk("grant_id", 32'(grant_id), 32'(m_port));
                    chk("core_message", 32'(core_message), 32'(m_msg));
                    chk("core_exponent", 32'(core_exponent), 32'(m_exp));
                    chk("core_modulus", 32'(core_modulus), 32'(m_mod));
                end
                if (|exp_ready) begin
                    m_open = 1; m_port = m_win; m_rcyc = cyc; m_gocnt = 0;
                    m_msg = op_msg[m_win]; m_exp = op_exp[m_win]; m_mod = op_mod[m_win];
                end
                if (exp_go) begin
                    m_gocnt++;
                    if (core_done) begin
                        m_pend = 1; m_pcyph = modexp(m_msg, m_exp, m_mod); m_perr = 0;
                    end else if (m_gocnt == TMO) begin
                        m_pend = 1; m_pcyph = '0; m_perr = 1;
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic set_job(input int p, input logic [W-1:0] m, input logic [W-1:0] e,
                           input logic [W-1:0] md, input int n);
        op_msg[p] = m; op_exp[p] = e; op_mod[p] = md;
        left[p] = n;
        req_valid[p] = (n > 0);
    endtask

    task automatic wait_rsps(input int n);
        int t = 0;
        while (rsp_port.size() < n && t < 3000) begin @(negedge clk); #1; t++; end
        chk("wait_rsp_budget", 32'(rsp_port.size() >= n), 1);
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rise_cyc.size() < n && t < 3000) begin @(negedge clk); #1; t++; end
        chk("wait_go_budget", 32'(rise_cyc.size() >= n), 1);
    endtask

    int b, h, r, f;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin op_msg[i] = '0; op_exp[i] = '0; op_mod[i] = '0; end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Single port0 job
        b = rsp_port.size(); h = hs_port.size();
        sync(); set_job(0, 16'd8, 16'd13, 16'd77, 1);
        wait_rsps(b + 1);
        chk("t1_port", 32'(rsp_port[b]), 0);
        chk("t1_cypher", 32'(rsp_cyph[b]), 32'h32);
        chk("t1_error", 32'(rsp_err[b]), 0);
        chk("t1_ready_pulses", 32'(hs_port.size() - h), 1);

        // Both ports valid together after reset
        sync(); reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        b = rsp_port.size(); h = hs_port.size();
        set_job(0, 16'd8, 16'd13, 16'd77, 1);
        set_job(1, 16'h32, 16'd37, 16'd77, 1);
        wait_rsps(b + 2);
        chk("t2_first_port", 32'(rsp_port[b]), 0);
        chk("t2_first_cypher", 32'(rsp_cyph[b]), 32'h32);
        chk("t2_second_port", 32'(rsp_port[b+1]), 1);
        chk("t2_second_cypher", 32'(rsp_cyph[b+1]), 32'h08);
        chk("t2_grant_order", 32'({hs_port[h][1:0], hs_port[h+1][1:0]}), 32'b0001);

        // Continuous re-requests alternate
        b = rsp_port.size(); h = hs_port.size();
        sync(); set_job(0, 16'd8, 16'd13, 16'd77, 2); set_job(1, 16'h32, 16'd37, 16'd77, 2);
        wait_rsps(b + 4);
        for (int k = 0; k < 4; k++) chk("t3_grant_order", 32'(hs_port[h+k]), 32'(k % 2));

        // Watchdog abort, queued job then completes
        b = rsp_port.size(); r = rise_cyc.size(); f = fall_cyc.size();
        sync(); mode = M_HANG; set_job(0, 16'd8, 16'd13, 16'd77, 1);
        wait_rises(r + 1);
        sync(); set_job(1, 16'h32, 16'd37, 16'd77, 1);
        wait_rsps(b + 1);
        chk("t4_abort_error", 32'(rsp_err[b]), 1);
        chk("t4_abort_cypher", 32'(rsp_cyph[b]), 0);
        chk("t4_abort_port", 32'(rsp_port[b]), 0);
        chk("t4_go_high_cycles", 32'(fall_cyc[f] - rise_cyc[r]), 64);
        sync(); mode = M_NORMAL; lat = 5;
        wait_rsps(b + 2);
        chk("t4_next_port", 32'(rsp_port[b+1]), 1);
        chk("t4_next_cypher", 32'(rsp_cyph[b+1]), 32'h08);
        chk("t4_next_error", 32'(rsp_err[b+1]), 0);

        // Reset mid-job
        r = rise_cyc.size();
        sync(); mode = M_HANG; set_job(0, 16'd8, 16'd13, 16'd77, 1);
        wait_rises(r + 1);
        repeat (3) @(posedge clk);
        #2; left[0] = 0; req_valid = '0; reset = 1'b0;
        #1;
        chk("t5_go_now", 32'(core_go), 0);
        chk("t5_busy_now", 32'(busy), 0);
        chk("t5_ready_now", 32'(req_ready), 0);
        chk("t5_rsp_now", 32'(rsp_valid), 0);
        b = rsp_port.size(); h = hs_port.size();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1; mode = M_NORMAL;
        set_job(1, 16'h32, 16'd37, 16'd77, 1);
        wait_rsps(b + 1);
        chk("t5_no_abort_rsp", 32'(rsp_port[b]), 1);
        chk("t5_grant", 32'(hs_port[h]), 1);
        chk("t5_grant_id", 32'(grant_id), 1);
        chk("t5_cypher", 32'(rsp_cyph[b]), 32'h08);

        // Done stuck high: exact gap spacing
        b = rsp_port.size(); h = hs_port.size(); r = rise_cyc.size(); f = fall_cyc.size();
        sync(); mode = M_STUCK; set_job(0, 16'd8, 16'd13, 16'd77, 2); set_job(1, 16'h32, 16'd37, 16'd77, 2);
        wait_rsps(b + 4);
        for (int k = 0; k < 4; k++) chk("t6_go_high", 32'(fall_cyc[f+k] - rise_cyc[r+k]), 1);
        for (int k = 0; k < 3; k++) begin
            chk("t6_go_low", 32'(rise_cyc[r+k+1] - fall_cyc[f+k]), 32'(GAP + 2));
            chk("t6_rsp_to_ready", 32'(hs_cyc[h+k+1] - rsp_cyc[b+k]), 32'(GAP));
        end

        // Done coincident with watchdog expiry
        b = rsp_port.size(); r = rise_cyc.size(); f = fall_cyc.size();
        sync(); mode = M_NORMAL; lat = 64; set_job(0, 16'd8, 16'd13, 16'd77, 1);
        wait_rsps(b + 1);
        chk("t6_tie_error", 32'(rsp_err[b]), 0);
        chk("t6_tie_cypher", 32'(rsp_cyph[b]), 32'h32);
        chk("t6_tie_go_high", 32'(fall_cyc[f] - rise_cyc[r]), 64);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
